// File: rtl/fmap_pingpong_mem_pkg.sv
// Shared definitions for the ping-pong feature-map buffer: bank-state codes,
// frame-depth helper and the debug view of the bank controller.
package fmap_pingpong_mem_pkg;

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;

  function automatic int mem_depth(input int ifm_size);
    return ifm_size * ifm_size;
  endfunction

  typedef struct packed {
    logic [1:0] bank1_state;
    logic [1:0] bank0_state;
    logic       wr_ptr;
    logic       rd_ptr;
  } fmap_debug_t;

endpackage

// File: rtl/true_dual_port_memory.sv
// Plain true dual-port RAM; each port reads or writes when enabled. Read data
// registers update only on reads, so a write never disturbs the read output.
module true_dual_port_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= din_a;
      else      dout_a      <= mem[addr_a];
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= din_b;
      else      dout_b      <= mem[addr_b];
    end
  end

endmodule

// File: rtl/fmap_pingpong_mem.sv
// Two-bank ping-pong feature-map buffer: the producer fills one bank while
// the consumer reads the other through two independent read ports.
module fmap_pingpong_mem
  import fmap_pingpong_mem_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int NUM_CHANNELS     = 2,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   wr_data,
  output logic                                 wr_frame_done,
  output logic                                 rd_frame_valid,
  input  logic                                 rd_en_A,
  input  logic                                 rd_en_B,
  input  logic [ADDRESS_SIZE_IFM-1:0]          rd_addr_A,
  input  logic [ADDRESS_SIZE_IFM-1:0]          rd_addr_B,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   rd_data_A,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   rd_data_B,
  input  logic                                 rd_release,
  output logic [1:0]                           banks_full,
  output fmap_debug_t                          debug
);

  localparam int WORD_W    = NUM_CHANNELS * DATA_WIDTH;
  localparam int MEM_DEPTH = mem_depth(IFM_SIZE);
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(MEM_DEPTH - 1);

  // Handshake: a write transfers when wr_valid && wr_ready on a rising edge;
  // wr_ready depends only on the full flag of the bank being written.
  logic [1:0][1:0]              bank_state;
  logic [ADDRESS_SIZE_IFM-1:0]  wr_addr;
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic                         wr_fire;
  logic                         frame_end;
  logic                         rel_fire;
  logic [1:0]                   wr_sel;
  logic [1:0]                   rd_a_sel;
  logic [1:0]                   rd_b_sel;
  logic [1:0][WORD_W-1:0]       q_a;
  logic [1:0][WORD_W-1:0]       q_b;
  logic                         rd_seen_A;
  logic                         rd_seen_B;
  logic                         rd_bank_A;
  logic                         rd_bank_B;

  assign banks_full[0]  = (bank_state[0] == BANK_FULL);
  assign banks_full[1]  = (bank_state[1] == BANK_FULL);
  assign wr_ready       = ~banks_full[wr_ptr];
  assign rd_frame_valid = banks_full[rd_ptr];
  assign wr_fire        = wr_valid & wr_ready;
  assign frame_end      = wr_fire & (wr_addr == LAST_ADDR);
  assign rel_fire       = rd_release & rd_frame_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_state    <= {BANK_EMPTY, BANK_EMPTY};
      wr_addr       <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_frame_done <= 1'b0;
    end else begin
      wr_frame_done <= frame_end;
      if (wr_fire) wr_addr <= frame_end ? '0 : wr_addr + 1'b1;
      if (frame_end) wr_ptr <= ~wr_ptr;
      if (rel_fire) rd_ptr <= ~rd_ptr;
      // The released bank is full and so never the bank being written.
      for (int b = 0; b < 2; b++) begin
        if (rel_fire && rd_ptr == b[0])
          bank_state[b] <= BANK_EMPTY;
        else if (wr_fire && wr_ptr == b[0])
          bank_state[b] <= frame_end ? BANK_FULL : BANK_FILLING;
      end
    end
  end

  // Port A is shared: a bank is never written and read in the same cycle,
  // since reads need that bank full and writes need it not full.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_sel[b]   = wr_fire & (wr_ptr == 1'(b));
    assign rd_a_sel[b] = rd_en_A & rd_frame_valid & (rd_ptr == 1'(b));
    assign rd_b_sel[b] = rd_en_B & rd_frame_valid & (rd_ptr == 1'(b));
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      true_dual_port_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDRESS_SIZE_IFM),
        .DEPTH      (MEM_DEPTH)
      ) u_mem (
        .clk    (clk),
        .en_a   (wr_sel[b] | rd_a_sel[b]),
        .we_a   (wr_sel[b]),
        .addr_a (wr_sel[b] ? wr_addr : rd_addr_A),
        .din_a  (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .dout_a (q_a[b][c*DATA_WIDTH +: DATA_WIDTH]),
        .en_b   (rd_b_sel[b]),
        .we_b   (1'b0),
        .addr_b (rd_addr_B),
        .din_b  ({DATA_WIDTH{1'b0}}),
        .dout_b (q_b[b][c*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

  // Remember which bank produced the last read; until the first read after
  // reset the outputs read as zero because the RAM registers are not reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_seen_A <= 1'b0;
      rd_seen_B <= 1'b0;
      rd_bank_A <= 1'b0;
      rd_bank_B <= 1'b0;
    end else begin
      if (|rd_a_sel) begin
        rd_seen_A <= 1'b1;
        rd_bank_A <= rd_ptr;
      end
      if (|rd_b_sel) begin
        rd_seen_B <= 1'b1;
        rd_bank_B <= rd_ptr;
      end
    end
  end

  assign rd_data_A = rd_seen_A ? q_a[rd_bank_A] : '0;
  assign rd_data_B = rd_seen_B ? q_b[rd_bank_B] : '0;

  assign debug.bank1_state = bank_state[1];
  assign debug.bank0_state = bank_state[0];
  assign debug.wr_ptr      = wr_ptr;
  assign debug.rd_ptr      = rd_ptr;

endmodule

// File: tb/tb_fmap_pingpong_mem.sv
// Directed bench for fmap_pingpong_mem (IFM_SIZE=4, 2 channels x 32 bits)
// with a frame-level reference model compared on every falling edge.
module tb_fmap_pingpong_mem;
  import fmap_pingpong_mem_pkg::*;

  localparam int DW    = 32;
  localparam int NC    = 2;
  localparam int W     = NC * DW;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          wr_frame_done;
  logic          rd_frame_valid;
  logic          rd_en_A;
  logic          rd_en_B;
  logic [AW-1:0] rd_addr_A;
  logic [AW-1:0] rd_addr_B;
  logic [W-1:0]  rd_data_A;
  logic [W-1:0]  rd_data_B;
  logic          rd_release;
  logic [1:0]    banks_full;
  fmap_debug_t   debug;

  int checks   = 0;
  int failures = 0;
  int done_pulses = 0;

  fmap_pingpong_mem #(
    .DATA_WIDTH   (DW),
    .IFM_SIZE     (4),
    .NUM_CHANNELS (NC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_frame_done  (wr_frame_done),
    .rd_frame_valid (rd_frame_valid),
    .rd_en_A        (rd_en_A),
    .rd_en_B        (rd_en_B),
    .rd_addr_A      (rd_addr_A),
    .rd_addr_B      (rd_addr_B),
    .rd_data_A      (rd_data_A),
    .rd_data_B      (rd_data_B),
    .rd_release     (rd_release),
    .banks_full     (banks_full),
    .debug          (debug)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_mem [2][DEPTH];
  bit           m_full [2];
  bit           m_wr;
  bit           m_rd;
  int           m_cnt;
  bit           m_done;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_full[0] = 0; m_full[1] = 0;
      m_wr = 0; m_rd = 0; m_cnt = 0; m_done = 0;
      m_a = '0; m_b = '0;
    end else begin
      bit valid, rel, old_rd;
      valid  = m_full[m_rd];
      old_rd = m_rd;
      rel    = rd_release && valid;
      if (rd_en_A && valid) m_a = m_mem[m_rd][rd_addr_A];
      if (rd_en_B && valid) m_b = m_mem[m_rd][rd_addr_B];
      m_done = 0;
      if (wr_valid && !m_full[m_wr]) begin
        m_mem[m_wr][m_cnt] = wr_data;
        if (m_cnt == DEPTH - 1) begin
          m_full[m_wr] = 1;
          m_wr   = !m_wr;
          m_cnt  = 0;
          m_done = 1;
        end else begin
          m_cnt++;
        end
      end
      if (rel) begin
        m_full[old_rd] = 0;
        m_rd = !m_rd;
      end
    end
  end

  function automatic logic [1:0] exp_state(input int b);
    if (m_full[b]) return BANK_FULL;
    if (m_wr == b[0] && m_cnt > 0) return BANK_FILLING;
    return BANK_EMPTY;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr_frame_done === 1'b1) done_pulses++;
    check("wr_ready",       W'(wr_ready),       W'(!m_full[m_wr]));
    check("rd_frame_valid", W'(rd_frame_valid), W'(m_full[m_rd]));
    check("banks_full",     W'(banks_full),     W'({m_full[1], m_full[0]}));
    check("wr_frame_done",  W'(wr_frame_done),  W'(m_done));
    check("rd_data_A",      rd_data_A,          m_a);
    check("rd_data_B",      rd_data_B,          m_b);
    check("rd_ptr",         W'(debug.rd_ptr),   W'(m_rd));
    check("wr_ptr",         W'(debug.wr_ptr),   W'(m_wr));
    check("bank0_state",    W'(debug.bank0_state), W'(exp_state(0)));
    check("bank1_state",    W'(debug.bank1_state), W'(exp_state(1)));
  end

  // ---------------- drivers ----------------
  function automatic logic [W-1:0] word(input int i);
    return {32'(100 + i), 32'(i)};
  endfunction

  task automatic write_words(input int first, input int n, input bit release_last);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      wr_valid   = 1'b1;
      wr_data    = word(first + k);
      rd_release = release_last && (k == n - 1);
    end
    @(posedge clk); #1;
    wr_valid   = 1'b0;
    rd_release = 1'b0;
  endtask

  task automatic read_pair(input int a, input int b);
    @(posedge clk); #1;
    rd_en_A = 1'b1; rd_addr_A = AW'(a);
    rd_en_B = 1'b1; rd_addr_B = AW'(b);
    @(posedge clk); #1;
    rd_en_A = 1'b0; rd_en_B = 1'b0;
  endtask

  task automatic release_once();
    @(posedge clk); #1;
    rd_release = 1'b1;
    @(posedge clk); #1;
    rd_release = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_en_A = 1'b0; rd_en_B = 1'b0; rd_addr_A = '0; rd_addr_B = '0;
    rd_release = 1'b0;
    #12;
    check("reset banks_full", W'(banks_full), W'(0));
    check("reset wr_ready",   W'(wr_ready),   W'(1));
    check("reset rd_data_A",  rd_data_A,      W'(0));
    @(posedge clk); #3 reset_n = 1'b1;

    // first frame lands in bank 0
    write_words(0, 16, 1'b0);
    check("f1 done",       W'(wr_frame_done), W'(1));
    check("f1 valid",      W'(rd_frame_valid), W'(1));
    check("f1 banks_full", W'(banks_full), W'(2'b01));
    @(posedge clk); #1;
    check("f1 pulse count", W'(done_pulses), W'(1));

    read_pair(5, 9);
    check("f1 rd_A", rd_data_A, {32'd105, 32'd5});
    check("f1 rd_B", rd_data_B, {32'd109, 32'd9});

    // second frame completes in the same cycle as the release of bank 0
    write_words(16, 16, 1'b1);
    check("swap banks_full", W'(banks_full), W'(2'b10));
    check("swap rd_ptr",     W'(debug.rd_ptr), W'(1));
    check("swap wr_ready",   W'(wr_ready), W'(1));

    // third frame fills bank 0: both full, extra writes ignored
    write_words(32, 16, 1'b0);
    check("both full",     W'(banks_full), W'(2'b11));
    check("both wr_ready", W'(wr_ready), W'(0));
    write_words(900, 3, 1'b0);
    check("ignored banks_full", W'(banks_full), W'(2'b11));
    read_pair(4, 15);
    check("full rd_A", rd_data_A, {32'd120, 32'd20});
    check("full rd_B", rd_data_B, {32'd131, 32'd31});

    release_once();
    read_pair(7, 0);
    check("f3 rd_A", rd_data_A, {32'd139, 32'd39});
    check("f3 rd_B", rd_data_B, {32'd132, 32'd32});
    release_once();
    check("drained banks_full", W'(banks_full), W'(2'b00));

    // release and read with no valid frame change nothing
    release_once();
    check("idle rel rd_ptr", W'(debug.rd_ptr), W'(1));
    read_pair(1, 2);
    check("idle rd_A hold", rd_data_A, {32'd139, 32'd39});
    check("idle rd_B hold", rd_data_B, {32'd132, 32'd32});

    // reset in the middle of a partial frame
    write_words(500, 7, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rst rd_data_A", rd_data_A, W'(0));
    check("rst rd_data_B", rd_data_B, W'(0));
    check("rst banks_full", W'(banks_full), W'(0));
    check("rst valid", W'(rd_frame_valid), W'(0));
    check("rst ptrs", W'({debug.wr_ptr, debug.rd_ptr}), W'(0));
    @(posedge clk); #3 reset_n = 1'b1;

    write_words(200, 16, 1'b0);
    check("post-rst banks_full", W'(banks_full), W'(2'b01));
    read_pair(0, 15);
    check("post-rst rd_A", rd_data_A, {32'd300, 32'd200});
    check("post-rst rd_B", rd_data_B, {32'd315, 32'd215});

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
